// File: rtl/phosphor_trail_gen.sv
// Phosphor trail generator.
// Draws a moving line pattern from the pixel coordinates and the frame
// counter, and keeps N_LAG older copies of that line visible with falling
// brightness, like the afterglow on a CRT. The newest copy is the head of
// the trail. The pixel colour is registered, so it appears one clk after
// hpos/vpos.
module phosphor_trail_gen #(
  parameter int N_LAG = 15,
  parameter int FN_W  = 9,
  parameter int ACT_W = 512,
  parameter int ACT_H = 480
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [9:0]      hpos,
  input  logic [9:0]      vpos,
  input  logic            vsync,
  input  logic [1:0]      mode,
  input  logic [1:0]      tint,
  input  logic            pause,
  input  logic            step,
  output logic [1:0]      r,
  output logic [1:0]      g,
  output logic [1:0]      b,
  output logic [FN_W-1:0] frame_no
);

  typedef enum logic [1:0] {
    MODE_XOR = 2'd0,
    MODE_ADD = 2'd1,
    MODE_SUB = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    TINT_GREEN = 2'd0,
    TINT_AMBER = 2'd1,
    TINT_CYAN  = 2'd2,
    TINT_WHITE = 2'd3
  } tint_e;

  // Brightness bands: the first quarter of the trail is full brightness,
  // the rest of the first half is medium, and the remainder is dim.
  localparam logic [5:0] QUARTER_AGE = 6'((N_LAG + 3) / 4);
  localparam logic [5:0] HALF_AGE    = 6'((N_LAG + 1) / 2);
  localparam bit         HEAD_EN     = (N_LAG > 1);
  localparam logic [10:0] ACT_W_L    = 11'(ACT_W);
  localparam logic [10:0] ACT_H_L    = 11'(ACT_H);

  // Frame control state.
  logic            vs_q, vs_d;
  logic            seen_low_q, seen_low_d;
  logic            step_pend_q, step_pend_d;
  logic [FN_W-1:0] frame_q, frame_d;
  mode_e           mode_q, mode_d;
  tint_e           tint_q, tint_d;

  // Pixel output state.
  logic [1:0]      r_q, r_d;
  logic [1:0]      g_q, g_d;
  logic [1:0]      b_q, b_d;

  logic            frame_edge;
  logic            advance;

  // Detect the vsync rise, then update the frame counter, the pending step
  // and the mode/tint shadows. seen_low_q keeps vsync from counting as a
  // rise when it is already high as reset is released.
  always_comb begin
    frame_edge  = vsync & ~vs_q & seen_low_q;
    advance     = frame_edge & (~pause | step_pend_q | step);
    vs_d        = vsync;
    seen_low_d  = seen_low_q | ~vsync;
    step_pend_d = frame_edge ? 1'b0 : (step_pend_q | step);
    frame_d     = advance ? frame_q + 1'b1 : frame_q;
    mode_d      = frame_edge ? mode_e'(mode) : mode_q;
    tint_d      = frame_edge ? tint_e'(tint) : tint_q;
  end

  // Frame control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q        <= 1'b0;
      seen_low_q  <= 1'b0;
      step_pend_q <= 1'b0;
      frame_q     <= '0;
      mode_q      <= MODE_XOR;
      tint_q      <= TINT_GREEN;
    end else begin
      vs_q        <= vs_d;
      seen_low_q  <= seen_low_d;
      step_pend_q <= step_pend_d;
      frame_q     <= frame_d;
      mode_q      <= mode_d;
      tint_q      <= tint_d;
    end
  end

  logic [FN_W-1:0] hx, vy, t_k, pat_k;
  logic            hit_any;
  logic [5:0]      age;

  // Compare the pixel with every trace in the trail. The scan runs from the
  // oldest trace to the newest, so the newest hit is the one that is kept.
  always_comb begin
    hx      = hpos[FN_W-1:0];
    vy      = vpos[FN_W-1:0];
    t_k     = '0;
    pat_k   = '0;
    hit_any = 1'b0;
    age     = '0;
    for (int k = N_LAG - 1; k >= 0; k--) begin
      t_k = frame_q - FN_W'(k);
      case (mode_q)
        MODE_ADD: pat_k = vy + t_k;
        MODE_SUB: pat_k = vy - t_k;
        default:  pat_k = vy ^ t_k;
      endcase
      if (hx == pat_k) begin
        hit_any = 1'b1;
        age     = 6'(k);
      end
    end
  end

  logic [1:0] lvl;
  logic       head;
  logic       visible;

  // Turn the trace age into a brightness level and a colour. The head is
  // drawn white; older traces take the shadow tint.
  always_comb begin
    lvl = 2'd0;
    if (hit_any) begin
      if (age == 6'd0)             lvl = 2'd3;
      else if (age < QUARTER_AGE)  lvl = 2'd3;
      else if (age < HALF_AGE)     lvl = 2'd2;
      else                         lvl = 2'd1;
    end
    head    = hit_any && (age == 6'd0) && HEAD_EN;
    visible = ({1'b0, hpos} < ACT_W_L) && ({1'b0, vpos} < ACT_H_L) &&
              (mode_q != MODE_OFF);
    r_d = 2'd0;
    g_d = 2'd0;
    b_d = 2'd0;
    if (visible) begin
      if (head) begin
        r_d = lvl;
        g_d = lvl;
        b_d = lvl;
      end else begin
        case (tint_q)
          TINT_GREEN: g_d = lvl;
          TINT_AMBER: begin
            r_d = lvl;
            g_d = lvl;
          end
          TINT_CYAN: begin
            g_d = lvl;
            b_d = lvl;
          end
          default: begin
            r_d = lvl;
            g_d = lvl;
            b_d = lvl;
          end
        endcase
      end
    end
  end

  // Pixel output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 2'd0;
      g_q <= 2'd0;
      b_q <= 2'd0;
    end else begin
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
    end
  end

  assign r        = r_q;
  assign g        = g_q;
  assign b        = b_q;
  assign frame_no = frame_q;

endmodule

// File: tb/tb_phosphor_trail_gen.sv
// Testbench for phosphor_trail_gen with the default parameters.
// Each pixel's expected colour comes from a behavioural model and goes on a
// queue when the pixel is driven. It is popped and compared one clk later,
// when the registered colour is valid.
module tb_phosphor_trail_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       vsync;
  logic [1:0] mode, tint;
  logic       pause, step;
  logic [1:0] r, g, b;
  logic [8:0] frame_no;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic [5:0] exp_q[$];
  logic [8:0] exp_frame;
  logic [1:0] sh_mode, sh_tint;
  logic       step_pend_m;

  phosphor_trail_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .hpos     (hpos),
    .vpos     (vpos),
    .vsync    (vsync),
    .mode     (mode),
    .tint     (tint),
    .pause    (pause),
    .step     (step),
    .r        (r),
    .g        (g),
    .b        (b),
    .frame_no (frame_no)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // The run is short; this stops it if something stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Expected colour {r,g,b} for one pixel with N_LAG=15, FN_W=9 and a
  // 512x480 drawn area.
  function automatic logic [5:0] model_pix(input logic [9:0] h, input logic [9:0] v);
    logic [8:0] t, pat;
    logic [1:0] lvl;
    int age;
    age = -1;
    pat = '0;
    if (h >= 10'd512 || v >= 10'd480 || sh_mode == 2'd3) return 6'd0;
    for (int a = 0; a < 15; a++) begin
      t = exp_frame - 9'(a);
      case (sh_mode)
        2'd0:    pat = v[8:0] ^ t;
        2'd1:    pat = v[8:0] + t;
        default: pat = v[8:0] - t;
      endcase
      if (age < 0 && h[8:0] == pat) age = a;
    end
    if (age < 0) return 6'd0;
    lvl = (age < 4) ? 2'd3 : (age < 8) ? 2'd2 : 2'd1;
    if (age == 0) return {lvl, lvl, lvl};
    case (sh_tint)
      2'd0:    return {2'd0, lvl, 2'd0};
      2'd1:    return {lvl, lvl, 2'd0};
      2'd2:    return {2'd0, lvl, lvl};
      default: return {lvl, lvl, lvl};
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp_v);
    cmp_cnt++;
    assert (obs === exp_v) else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Drive one pixel coordinate on the falling edge and queue its expected colour.
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v);
    @(negedge clk);
    hpos = h;
    vpos = v;
    exp_q.push_back(model_pix(h, v));
  endtask

  // One clk later, pop the oldest expectation and compare it with the colour.
  task automatic samplePixel(input string tag);
    logic [5:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      cmp_cnt++;
      err_cnt++;
      $display("[TB] FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      checkOutput(tag, {3'b0, r, g, b}, {3'b0, e});
    end
  endtask

  task automatic pixel(input string tag, input logic [9:0] h, input logic [9:0] v);
    applyStimulus(h, v);
    samplePixel(tag);
  endtask

  // One vsync pulse, with the model's frame, step and shadow updates.
  task automatic vsyncPulse(input logic with_step);
    @(negedge clk);
    vsync = 1'b1;
    step  = with_step;
    if (!pause || step_pend_m || with_step) exp_frame = exp_frame + 9'd1;
    step_pend_m = 1'b0;
    sh_mode = mode;
    sh_tint = tint;
    @(negedge clk);
    vsync = 1'b0;
    step  = 1'b0;
    @(negedge clk);
  endtask

  task automatic stepPulse();
    @(negedge clk);
    step = 1'b1;
    step_pend_m = 1'b1;
    @(negedge clk);
    step = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    rst_n = 1'b0; hpos = '0; vpos = '0; vsync = 1'b0;
    mode = 2'd0; tint = 2'd0; pause = 1'b0; step = 1'b0;
    exp_frame = '0; sh_mode = 2'd0; sh_tint = 2'd0; step_pend_m = 1'b0;

    #3;
    checkOutput("reset_rgb", {3'b0, r, g, b}, 9'd0);
    checkOutput("reset_frame", frame_no, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Frame 0: the head is white, the previous trace is green, and a miss is black.
    pixel("head_f0", 10'd5, 10'd5);
    pixel("age1_f0", 10'd506, 10'd5);
    pixel("nohit_f0", 10'd5, 10'd6);

    // Advance to frame 10 and check the brightness bands.
    for (int i = 0; i < 10; i++) vsyncPulse(1'b0);
    checkOutput("frame10", frame_no, exp_frame);
    pixel("age7_lvl2", 10'd103, 10'd100);
    pixel("age12_lvl1", 10'd100 ^ 10'd510, 10'd100);
    pixel("age3_lvl3", 10'd100 ^ 10'd7, 10'd100);

    // A tint change takes effect only on the next vsync.
    tint = 2'd1;
    pixel("tint_held", 10'd100 ^ 10'd5, 10'd100);
    vsyncPulse(1'b0);
    vsyncPulse(1'b0);
    pixel("amber_age", 10'd100 ^ 10'd6, 10'd100);

    // Switching to ADD mid-frame keeps XOR until the vsync rise.
    mode = 2'd1;
    pixel("xor_held_head", 10'd100 ^ 10'd12, 10'd100);
    pixel("xor_held_addpt", 10'd112, 10'd100);
    vsyncPulse(1'b0);
    pixel("add_head", 10'd113, 10'd100);
    pixel("add_age8", 10'd105, 10'd100);

    // SUB mode, then OFF.
    mode = 2'd2; tint = 2'd2;
    vsyncPulse(1'b0);
    pixel("sub_head", 10'd200 - 10'(exp_frame), 10'd200);
    pixel("sub_age2_cyan", 10'd200 - 10'(exp_frame) + 10'd2, 10'd200);
    mode = 2'd3; tint = 2'd3;
    vsyncPulse(1'b0);
    pixel("off_head", 10'd200 - 10'(exp_frame), 10'd200);
    mode = 2'd0;
    vsyncPulse(1'b0);
    pixel("white_age9", 10'd50 ^ 10'(exp_frame - 9'd9), 10'd50);

    // Pause: vsyncs are ignored until a step is pending.
    pause = 1'b1;
    for (int i = 0; i < 3; i++) vsyncPulse(1'b0);
    checkOutput("pause_hold", frame_no, exp_frame);
    stepPulse();
    vsyncPulse(1'b0);
    vsyncPulse(1'b0);
    checkOutput("pause_step", frame_no, exp_frame);
    vsyncPulse(1'b1);
    vsyncPulse(1'b0);
    checkOutput("pause_step_same_edge", frame_no, exp_frame);
    pause = 1'b0;

    // Drawn-area bounds with patterns that would otherwise hit.
    tint = 2'd0;
    vsyncPulse(1'b0);
    pixel("h600_off", 10'd600, 10'd88 ^ 10'(exp_frame));
    pixel("v490_off", 10'd490 ^ 10'(exp_frame), 10'd490);
    pixel("h512_off", 10'd512, 10'(exp_frame));
    pixel("v479_on", 10'd479 ^ 10'(exp_frame), 10'd479);

    // Frame counter wrap; the trail stays continuous across it.
    for (int i = 0; i < 600 && exp_frame != 9'd511; i++) vsyncPulse(1'b0);
    checkOutput("frame511", frame_no, 9'd511);
    vsyncPulse(1'b0);
    checkOutput("frame_wrap", frame_no, 9'd0);
    pixel("wrap_age1", 10'd7 ^ 10'd511, 10'd7);
    vsyncPulse(1'b0);
    checkOutput("frame_after_wrap", frame_no, exp_frame);

    // Reset in the middle of a line, with vsync high when reset is released.
    applyStimulus(10'd9 ^ 10'(exp_frame), 10'd9);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    vsync = 1'b1;
    #1;
    checkOutput("async_rst_rgb", {3'b0, r, g, b}, 9'd0);
    checkOutput("async_rst_frame", frame_no, 9'd0);
    exp_q.delete();
    exp_frame = '0; sh_mode = 2'd0; sh_tint = 2'd0; step_pend_m = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pixel("post_rst_head", 10'd5, 10'd5);
    repeat (3) @(negedge clk);
    checkOutput("no_edge_vs_high", frame_no, 9'd0);
    vsync = 1'b0;
    @(negedge clk);
    vsync = 1'b1;
    exp_frame = exp_frame + 9'd1;
    @(negedge clk);
    vsync = 1'b0;
    checkOutput("edge_after_low", frame_no, exp_frame);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
